// File: rtl/panda_pkg.sv
// Shared types for the Panda pipeline controller: FSM states and PC source select.
package panda_pkg;

  typedef enum logic [1:0] {
    CTRL_RESET = 2'd0,
    CTRL_BOOT  = 2'd1,
    CTRL_RUN   = 2'd2,
    CTRL_HALT  = 2'd3
  } ctrl_state_e;

  typedef enum logic [0:0] {
    PC_BOOT = 1'b0,
    PC_JUMP = 1'b1
  } pc_sel_e;

  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned NumSrcRegs   = 2;

endpackage

// File: rtl/panda_hazard_detect.sv
// Combinational load-use detector: flags an ID source operand that depends on a load still in EX.
module panda_hazard_detect
  import panda_pkg::*;
(
  input  logic                    id_valid_i,
  input  logic [RegAddrWidth-1:0] id_rs1_addr_i,
  input  logic [RegAddrWidth-1:0] id_rs2_addr_i,
  input  logic                    id_rs1_used_i,
  input  logic                    id_rs2_used_i,
  input  logic                    ex_valid_i,
  input  logic                    ex_load_i,
  input  logic [RegAddrWidth-1:0] ex_rd_addr_i,
  output logic                    load_use_o
);

  logic [RegAddrWidth-1:0] rs_addr [NumSrcRegs];
  logic [NumSrcRegs-1:0]   rs_used;
  logic [NumSrcRegs-1:0]   rs_match;
  logic                    ex_writes_load;

  assign rs_addr[0] = id_rs1_addr_i;
  assign rs_addr[1] = id_rs2_addr_i;
  assign rs_used    = {id_rs2_used_i, id_rs1_used_i};

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign ex_writes_load = ex_valid_i & ex_load_i & (ex_rd_addr_i != '0);

  generate
    for (genvar gi = 0; gi < NumSrcRegs; gi++) begin : g_src
      assign rs_match[gi] = rs_used[gi] & (rs_addr[gi] == ex_rd_addr_i);
    end
  endgenerate

  assign load_use_o = ex_writes_load & id_valid_i & (|rs_match);

endmodule

// File: rtl/panda_controller.sv
// Pipeline controller for the Panda core: stall/flush/redirect sequencing,
// halt on illegal instruction and a saturating stall-cycle counter.
module panda_controller
  import panda_pkg::*;
#(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_enable_i,
  input  logic                id_valid_i,
  input  logic                illegal_instr_i,
  input  logic [4:0]          id_rs1_addr_i,
  input  logic [4:0]          id_rs2_addr_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic                ex_valid_i,
  input  logic                ex_load_i,
  input  logic [4:0]          ex_rd_addr_i,
  input  logic                branch_taken_i,
  input  logic                lsu_busy_i,
  output logic                pc_set_o,
  output pc_sel_e             pc_sel_o,
  output logic                if_stall_o,
  output logic                id_stall_o,
  output logic                ex_stall_o,
  output logic                id_flush_o,
  output logic                ex_flush_o,
  output logic                halted_o,
  output logic [CntWidth-1:0] stall_cnt_o
);

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  ctrl_state_e         state_reg, state_next;
  logic [CntWidth-1:0] stall_cnt_reg;
  logic                load_use;

  panda_hazard_detect u_hazard_detect (
    .id_valid_i    (id_valid_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_valid_i    (ex_valid_i),
    .ex_load_i     (ex_load_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .load_use_o    (load_use)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= CTRL_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_set_o   = 1'b0;
    pc_sel_o   = PC_BOOT;
    if_stall_o = 1'b0;
    id_stall_o = 1'b0;
    ex_stall_o = 1'b0;
    id_flush_o = 1'b0;
    ex_flush_o = 1'b0;

    case (state_reg)
      CTRL_RESET: begin
        if_stall_o = 1'b1;
        id_stall_o = 1'b1;
        ex_stall_o = 1'b1;
        if (fetch_enable_i) begin
          state_next = CTRL_BOOT;
        end
      end

      CTRL_BOOT: begin
        pc_set_o   = 1'b1;
        pc_sel_o   = PC_BOOT;
        id_flush_o = 1'b1;
        ex_flush_o = 1'b1;
        state_next = CTRL_RUN;
      end

      CTRL_RUN: begin
        // Priority chain: a pending memory access freezes everything, so
        // lower-priority events are simply re-seen once it completes.
        if (lsu_busy_i) begin
          if_stall_o = 1'b1;
          id_stall_o = 1'b1;
          ex_stall_o = 1'b1;
        end else if (branch_taken_i) begin
          pc_set_o   = 1'b1;
          pc_sel_o   = PC_JUMP;
          id_flush_o = 1'b1;
          ex_flush_o = 1'b1;
        end else if (id_valid_i && illegal_instr_i) begin
          if_stall_o = 1'b1;
          id_stall_o = 1'b1;
          ex_flush_o = 1'b1;
          state_next = CTRL_HALT;
        end else if (load_use) begin
          if_stall_o = 1'b1;
          id_stall_o = 1'b1;
          ex_flush_o = 1'b1;
        end
      end

      CTRL_HALT: begin
        if_stall_o = 1'b1;
        id_stall_o = 1'b1;
        ex_stall_o = 1'b1;
      end

      default: begin
        state_next = CTRL_RESET;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == CTRL_RUN) && if_stall_o && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CntOne;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign halted_o    = (state_reg == CTRL_HALT);

endmodule

// File: tb/tb_panda_controller.sv
// Directed scoreboard bench for panda_controller (default width plus a 4-bit counter instance).
module tb_panda_controller;
  import panda_pkg::*;

  typedef struct {
    string       tag;
    logic [7:0]  strb;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_enable_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic        illegal_instr_i = 1'b0;
  logic [4:0]  id_rs1_addr_i = '0;
  logic [4:0]  id_rs2_addr_i = '0;
  logic        id_rs1_used_i = 1'b0;
  logic        id_rs2_used_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_load_i = 1'b0;
  logic [4:0]  ex_rd_addr_i = '0;
  logic        branch_taken_i = 1'b0;
  logic        lsu_busy_i = 1'b0;

  logic        pc_set_o, if_stall_o, id_stall_o, ex_stall_o, id_flush_o, ex_flush_o, halted_o;
  pc_sel_e     pc_sel_o;
  logic [31:0] stall_cnt_o;

  logic        pc_set_4, if_stall_4, id_stall_4, ex_stall_4, id_flush_4, ex_flush_4, halted_4;
  pc_sel_e     pc_sel_4;
  logic [3:0]  stall_cnt_4;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_cnt = '0;
  logic [3:0]  model_cnt4 = '0;

  always #5 clk_i = ~clk_i;

  panda_controller u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
    .id_valid_i(id_valid_i), .illegal_instr_i(illegal_instr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_load_i(ex_load_i), .ex_rd_addr_i(ex_rd_addr_i),
    .branch_taken_i(branch_taken_i), .lsu_busy_i(lsu_busy_i),
    .pc_set_o(pc_set_o), .pc_sel_o(pc_sel_o), .if_stall_o(if_stall_o),
    .id_stall_o(id_stall_o), .ex_stall_o(ex_stall_o), .id_flush_o(id_flush_o),
    .ex_flush_o(ex_flush_o), .halted_o(halted_o), .stall_cnt_o(stall_cnt_o)
  );

  panda_controller #(.CntWidth(4)) u_dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
    .id_valid_i(id_valid_i), .illegal_instr_i(illegal_instr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_load_i(ex_load_i), .ex_rd_addr_i(ex_rd_addr_i),
    .branch_taken_i(branch_taken_i), .lsu_busy_i(lsu_busy_i),
    .pc_set_o(pc_set_4), .pc_sel_o(pc_sel_4), .if_stall_o(if_stall_4),
    .id_stall_o(id_stall_4), .ex_stall_o(ex_stall_4), .id_flush_o(id_flush_4),
    .ex_flush_o(ex_flush_4), .halted_o(halted_4), .stall_cnt_o(stall_cnt_4)
  );

  // Expected strobe vector: {pc_set, pc_sel, if_stall, id_stall, ex_stall, id_flush, ex_flush, halted}
  localparam logic [7:0] S_IDLE   = 8'b0000_0000;
  localparam logic [7:0] S_STALL3 = 8'b0011_1000;
  localparam logic [7:0] S_HALT   = 8'b0011_1001;
  localparam logic [7:0] S_BOOT   = 8'b1000_0110;
  localparam logic [7:0] S_JUMP   = 8'b1100_0110;
  localparam logic [7:0] S_BUBBLE = 8'b0011_0010;

  task automatic step(input string tag, input logic rst, input logic fe,
                      input logic idv, input logic ill,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2,
                      input logic exv, input logic exl, input logic [4:0] rd,
                      input logic br, input logic busy, input logic in_run,
                      input logic [7:0] exp_strb);
    exp_t e, got;
    logic [7:0] obs;
    @(posedge clk_i);
    #1;
    rst_ni = rst; fetch_enable_i = fe; id_valid_i = idv; illegal_instr_i = ill;
    id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rs1_used_i = u1; id_rs2_used_i = u2;
    ex_valid_i = exv; ex_load_i = exl; ex_rd_addr_i = rd;
    branch_taken_i = br; lsu_busy_i = busy;
    if (!rst) begin
      model_cnt  = '0;
      model_cnt4 = '0;
    end
    e.tag = tag; e.strb = exp_strb; e.cnt = model_cnt; e.cnt4 = model_cnt4;
    sb_q.push_back(e);
    @(negedge clk_i);
    got = sb_q.pop_front();
    obs = {pc_set_o, logic'(pc_sel_o), if_stall_o, id_stall_o, ex_stall_o,
           id_flush_o, ex_flush_o, halted_o};
    checks++;
    assert (obs === got.strb) else begin
      errors++;
      $error("FAIL %s strobes observed=%b expected=%b", got.tag, obs, got.strb);
    end
    checks++;
    assert (stall_cnt_o === got.cnt) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", got.tag, stall_cnt_o, got.cnt);
    end
    checks++;
    assert (stall_cnt_4 === got.cnt4) else begin
      errors++;
      $error("FAIL %s stall_cnt4 observed=%0d expected=%0d", got.tag, stall_cnt_4, got.cnt4);
    end
    $display("txn %-14s strb=%b cnt=%0d cnt4=%0d", got.tag, obs, stall_cnt_o, stall_cnt_4);
    if (in_run && exp_strb[5]) begin
      if (model_cnt != '1)  model_cnt  = model_cnt + 32'd1;
      if (model_cnt4 != '1) model_cnt4 = model_cnt4 + 4'd1;
    end
  endtask

  initial begin
    //   tag            rst fe idv ill rs1 rs2 u1 u2 exv exl rd  br bsy run expected
    step("reset",       0,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_STALL3);
    step("fetch_en",    1,  1, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_STALL3);
    step("boot",        1,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_BOOT);
    step("run_idle",    1,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  1,  S_IDLE);
    step("load_use",    1,  0, 1,  0,  5,  1,  1, 1, 1,  1,  5,  0, 0,  1,  S_BUBBLE);
    step("bubble",      1,  0, 1,  0,  5,  1,  1, 1, 0,  0,  0,  0, 0,  1,  S_IDLE);
    step("rd_x0",       1,  0, 1,  0,  0,  1,  1, 1, 1,  1,  0,  0, 0,  1,  S_IDLE);
    step("rs2_unused",  1,  0, 1,  0,  1,  7,  1, 0, 1,  1,  7,  0, 0,  1,  S_IDLE);
    step("load_use_rs2",1,  0, 1,  0,  1,  7,  1, 1, 1,  1,  7,  0, 0,  1,  S_BUBBLE);
    step("br_over_lu",  1,  0, 1,  0,  5,  1,  1, 1, 1,  1,  5,  1, 0,  1,  S_JUMP);
    for (int i = 0; i < 3; i++)
      step("busy_br",   1,  0, 1,  0,  0,  0,  0, 0, 0,  0,  0,  1, 1,  1,  S_STALL3);
    step("br_release",  1,  0, 1,  0,  0,  0,  0, 0, 0,  0,  0,  1, 0,  1,  S_JUMP);
    step("br_over_ill", 1,  0, 1,  1,  0,  0,  0, 0, 0,  0,  0,  1, 0,  1,  S_JUMP);
    step("illegal",     1,  0, 1,  1,  0,  0,  0, 0, 0,  0,  0,  0, 0,  1,  S_BUBBLE);
    step("halted",      1,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_HALT);
    step("halt_fe1",    1,  1, 1,  0,  0,  0,  0, 0, 0,  0,  0,  1, 0,  0,  S_HALT);
    step("halt_fe0",    1,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 1,  0,  S_HALT);
    step("halt_fe1b",   1,  1, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_HALT);
    step("rst_in_halt", 0,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_STALL3);
    step("refetch",     1,  1, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_STALL3);
    step("reboot",      1,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  S_BOOT);
    for (int i = 0; i < 20; i++)
      step("sat_busy",  1,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 1,  1,  S_STALL3);
    step("sat_done",    1,  0, 0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0,  1,  S_IDLE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
